// File: rtl/ir_pointer_if.sv
// ---------------------------------------------------------------------------
// ir_pointer_if
// Bundles the control-side inputs and fetch-side outputs of ir_pointer.
//   i_ir_regfile_en : mode from control (00 idle, 01 reset, 10 work, 11 idle)
//   i_cmd_valid/i_cmd/i_data/i_operand_a/i_operand_b : flow command
//   i_fetch_ready   : instruction memory accepts o_pointer
//   o_pointer/o_fetch_valid : fetch request
//   o_waiting/o_stopped     : status
// master: the environment driving commands and consuming fetches.
// slave : ir_pointer itself.
// ---------------------------------------------------------------------------
interface ir_pointer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            i_ir_regfile_en;
  logic                  i_cmd_valid;
  logic [2:0]            i_cmd;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] i_operand_a;
  logic [DATA_WIDTH-1:0] i_operand_b;
  logic                  i_fetch_ready;
  logic [DATA_WIDTH-1:0] o_pointer;
  logic                  o_fetch_valid;
  logic                  o_waiting;
  logic                  o_stopped;

  modport master (
    output i_ir_regfile_en, i_cmd_valid, i_cmd, i_data,
           i_operand_a, i_operand_b, i_fetch_ready,
    input  o_pointer, o_fetch_valid, o_waiting, o_stopped
  );

  modport slave (
    input  i_ir_regfile_en, i_cmd_valid, i_cmd, i_data,
           i_operand_a, i_operand_b, i_fetch_ready,
    output o_pointer, o_fetch_valid, o_waiting, o_stopped
  );
endinterface

// File: rtl/ir_pointer.sv
// ---------------------------------------------------------------------------
// ir_pointer
// Instruction-pointer stage. Maintains the fetch address, the jump target
// and a wait counter, driven by the mode and flow commands from control.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ir_pointer_if.slave (mode, command, operands, fetch handshake,
//           pointer and status outputs)
// ---------------------------------------------------------------------------
module ir_pointer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  ir_pointer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CMD_LARGER  = 3'd0,
    CMD_SMALLER = 3'd1,
    CMD_EQUAL   = 3'd2,
    CMD_UNEQUAL = 3'd3,
    CMD_DIRECT  = 3'd4,
    CMD_ADDRESS = 3'd5,
    CMD_WAIT    = 3'd6,
    CMD_STOP    = 3'd7
  } cmd_e;

  localparam logic [1:0] MODE_RESET = 2'b01;
  localparam logic [1:0] MODE_WORK  = 2'b10;

  state_e                state_q,   state_d;
  logic [DATA_WIDTH-1:0] pointer_q, pointer_d;
  logic [DATA_WIDTH-1:0] target_q,  target_d;
  logic [DATA_WIDTH-1:0] count_q,   count_d;

  logic                  fetch_valid;
  logic                  jump_taken;
  logic [DATA_WIDTH-1:0] pointer_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      pointer_q <= RESET_ADDR;
      target_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
      target_q  <= target_d;
      count_q   <= count_d;
    end
  end

  // Branch condition for the compare/direct commands; operands are unsigned.
  always_comb begin
    jump_taken = 1'b0;
    if (bus.i_cmd_valid) begin
      unique case (cmd_e'(bus.i_cmd))
        CMD_LARGER:  jump_taken = (bus.i_operand_a >  bus.i_operand_b);
        CMD_SMALLER: jump_taken = (bus.i_operand_a <  bus.i_operand_b);
        CMD_EQUAL:   jump_taken = (bus.i_operand_a == bus.i_operand_b);
        CMD_UNEQUAL: jump_taken = (bus.i_operand_a != bus.i_operand_b);
        CMD_DIRECT:  jump_taken = 1'b1;
        default:     jump_taken = 1'b0;
      endcase
    end
  end

  // Advance on a completed handshake only; wraps naturally at the width.
  assign pointer_step = (fetch_valid && bus.i_fetch_ready)
                      ? pointer_q + DATA_WIDTH'(1) : pointer_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    target_d    = target_q;
    count_d     = count_q;
    fetch_valid = 1'b0;

    unique case (state_q)
      ST_RST: begin
        if (bus.i_ir_regfile_en == MODE_WORK) state_d = ST_RUN;
      end

      ST_RUN: begin
        // Outside work mode the pointer freezes and commands are ignored.
        if (bus.i_ir_regfile_en == MODE_WORK) begin
          fetch_valid = 1'b1;
          pointer_d   = pointer_step;
          if (jump_taken) begin
            // The current request is dropped even if it was accepted.
            pointer_d = target_q;
          end else if (bus.i_cmd_valid) begin
            unique case (cmd_e'(bus.i_cmd))
              CMD_ADDRESS: target_d = bus.i_data;
              CMD_WAIT: begin
                if (bus.i_data != '0) begin
                  count_d   = bus.i_data;
                  state_d   = ST_WAIT;
                  pointer_d = pointer_q;
                end
              end
              CMD_STOP: begin
                state_d   = ST_STOP;
                pointer_d = pointer_q;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WAIT: begin
        count_d = count_q - DATA_WIDTH'(1);
        if (count_q <= DATA_WIDTH'(1)) state_d = ST_RUN;
      end

      ST_STOP: ;

      default: state_d = ST_RST;
    endcase

    // Mode reset overrides every state and command.
    if (bus.i_ir_regfile_en == MODE_RESET) begin
      state_d     = ST_RST;
      pointer_d   = RESET_ADDR;
      target_d    = '0;
      count_d     = '0;
      fetch_valid = 1'b0;
    end
  end

  assign bus.o_pointer     = pointer_q;
  assign bus.o_fetch_valid = fetch_valid;
  assign bus.o_waiting     = (state_q == ST_WAIT);
  assign bus.o_stopped     = (state_q == ST_STOP);

endmodule

// File: tb/tb_ir_pointer.sv
// ---------------------------------------------------------------------------
// tb_ir_pointer
// Drives directed scenarios followed by random traffic into ir_pointer. A
// behavioural model predicts the outputs of every cycle and queues them; a
// monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_ir_pointer;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] ptr;
    logic         valid;
    logic         waiting;
    logic         stopped;
  } obs_t;

  logic clk;
  logic rst_n;

  ir_pointer_if #(.DATA_WIDTH(W)) bus ();

  ir_pointer #(.DATA_WIDTH(W), .RESET_ADDR('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t sb_q[$];
  int   cyc_no = 0;

  // Reference model: the pointer, target and a count of remaining wait
  // cycles, plus two flags for "held in reset" and "stopped".
  int model_ptr    = 0;
  int model_target = 0;
  int model_wait   = 0;
  bit model_in_rst = 1'b1;
  bit model_stop   = 1'b0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ptr=%02h v=%0b w=%0b s=%0b, expected ptr=%02h v=%0b w=%0b s=%0b",
               name, act.ptr, act.valid, act.waiting, act.stopped,
               exp.ptr, exp.valid, exp.waiting, exp.stopped);
    end
  endtask

  task automatic model_reset();
    model_ptr    = 0;
    model_target = 0;
    model_wait   = 0;
    model_in_rst = 1'b1;
    model_stop   = 1'b0;
  endtask

  // One clock cycle: apply inputs just after the rising edge, predict this
  // cycle's outputs, then advance the model to what the next edge produces.
  task automatic cyc(input logic [1:0] m, input logic cv, input logic [2:0] c,
                     input int d, input int a, input int b,
                     input logic rdy, input logic rn);
    obs_t e;
    bit   running, taken;
    @(posedge clk);
    #1;
    cyc_no++;
    bus.i_ir_regfile_en = m;
    bus.i_cmd_valid     = cv;
    bus.i_cmd           = c;
    bus.i_data          = W'(d);
    bus.i_operand_a     = W'(a);
    bus.i_operand_b     = W'(b);
    bus.i_fetch_ready   = rdy;
    rst_n               = rn;

    if (!rn) model_reset();
    running   = !model_in_rst && !model_stop && (model_wait == 0);
    e.ptr     = W'(model_ptr);
    e.valid   = running && (m == 2'b10);
    e.waiting = (model_wait > 0);
    e.stopped = model_stop;
    sb_q.push_back(e);

    if (!rn || m == 2'b01) begin
      model_reset();
    end else if (model_in_rst) begin
      if (m == 2'b10) model_in_rst = 1'b0;
    end else if (model_stop) begin
      // sticky until reset
    end else if (model_wait > 0) begin
      model_wait--;
    end else if (m == 2'b10) begin
      taken = cv && ((c == 3'd0 && a >  b) || (c == 3'd1 && a <  b) ||
                     (c == 3'd2 && a == b) || (c == 3'd3 && a != b) ||
                     (c == 3'd4));
      if (taken)                          model_ptr  = model_target;
      else if (cv && c == 3'd7)           model_stop = 1'b1;
      else if (cv && c == 3'd6 && d != 0) model_wait = d;
      else begin
        if (cv && c == 3'd5) model_target = d;
        if (rdy) model_ptr = (model_ptr + 1) % (1 << W);
      end
    end
  endtask

  // Shorthands for work-mode cycles.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b10, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic cmd(input logic [2:0] c, input int d, input int a, input int b);
    cyc(2'b10, 1'b1, c, d, a, b, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    obs_t act, exp;
    if (sb_q.size() > 0) begin
      exp         = sb_q.pop_front();
      act.ptr     = bus.o_pointer;
      act.valid   = bus.o_fetch_valid;
      act.waiting = bus.o_waiting;
      act.stopped = bus.o_stopped;
      check($sformatf("cycle%0d", cyc_no), act, exp);
    end
  end

  initial begin
    rst_n               = 1'b0;
    bus.i_ir_regfile_en = 2'b00;
    bus.i_cmd_valid     = 1'b0;
    bus.i_cmd           = 3'd0;
    bus.i_data          = '0;
    bus.i_operand_a     = '0;
    bus.i_operand_b     = '0;
    bus.i_fetch_ready   = 1'b0;

    // Reset, then release together with work mode.
    cyc(2'b00, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b0);
    cyc(2'b10, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b1);
    idle(5);                                       // pointer 0..4
    for (int i = 0; i < 3; i++)                    // stall at 5
      cyc(2'b10, 1'b0, 3'd0, 0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Target load and conditional jumps.
    cmd(3'd5, 8'h40, 0, 0);
    cmd(3'd0, 0, 3, 7);                            // not taken
    cmd(3'd0, 0, 7, 3);                            // taken -> 0x40
    idle(1);
    cmd(3'd1, 0, 2, 8);                            // smaller taken
    cmd(3'd2, 0, 9, 9);                            // equal taken
    cmd(3'd3, 0, 9, 9);                            // unequal not taken
    cmd(3'd5, 8'h0A, 0, 0);
    cmd(3'd4, 0, 0, 0);                            // direct -> 10

    // Wait at pointer 10, then a zero-length wait.
    cmd(3'd6, 4, 0, 0);
    idle(6);
    cmd(3'd6, 0, 0, 0);
    idle(2);

    // Wrap through 0xFF.
    cmd(3'd5, 8'hFD, 0, 0);
    cmd(3'd4, 0, 0, 0);
    idle(5);

    // Freeze outside work mode, commands ignored.
    cyc(2'b00, 1'b1, 3'd4, 0, 0, 0, 1'b1, 1'b1);
    cyc(2'b11, 1'b1, 3'd7, 0, 0, 0, 1'b1, 1'b1);
    idle(1);

    // Stop, commands ignored, mode reset recovers.
    cmd(3'd7, 0, 0, 0);
    cmd(3'd4, 0, 0, 0);
    cmd(3'd6, 3, 0, 0);
    idle(2);
    cyc(2'b01, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b1);
    idle(4);

    // Mode reset mid-wait.
    cmd(3'd6, 5, 0, 0);
    idle(2);
    cyc(2'b01, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset mid-wait.
    cmd(3'd5, 8'h33, 0, 0);
    cmd(3'd6, 6, 0, 0);
    idle(2);
    cyc(2'b10, 1'b0, 3'd0, 0, 0, 0, 1'b1, 1'b0);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic [1:0]  m;
      logic [2:0]  c;
      int          d;
      r = int'($urandom_range(0, 15));
      m = (r == 0) ? 2'b01 : (r == 1) ? 2'b00 : (r == 2) ? 2'b11 : 2'b10;
      c = 3'($urandom_range(0, 7));
      d = (c == 3'd6) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
      cyc(m, ($urandom_range(0, 2) == 0), c, d,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_pointer.md
# ir_pointer

Instruction-pointer stage directly downstream of `control`. It consumes the 2-bit instruction-register mode (`o_ir_regfile_en`) and the decoded flow commands for `DEVICE_CONTROLLER` ports: jump larger/smaller/equal/unequal/direct, jump address, wait and stop. From these it maintains the instruction fetch address and presents it to instruction memory with a valid/ready handshake. It owns the pointer, the jump-target register and the wait counter.

## Interface
- `DATA_WIDTH`, default 8: width of the pointer, the target register, the operands and the wait count.
- `RESET_ADDR`, default 0: pointer value after reset and in the RST state.

Ports:
- `clk`  in  1  : the single clock; all state changes on its rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `i_ir_regfile_en`  in  2  : mode from control: 2'b00 idle, 2'b01 reset, 2'b10 work, 2'b11 treated as idle.
- `i_cmd_valid`  in  1  : a flow command is present this cycle.
- `i_cmd`  in  3  : the command:
  - 0 larger, 1 smaller, 2 equal, 3 unequal
  - 4 direct, 5 address (load target)
  - 6 wait, 7 stop
- `i_data`  in  DATA_WIDTH  : target value for cmd 5; cycle count for cmd 6.
- `i_operand_a`, `i_operand_b`  in  DATA_WIDTH each  : comparison operands, unsigned.
- `i_fetch_ready`  in  1  : instruction memory accepts the address.
- `o_pointer`  out  DATA_WIDTH  : current fetch address (registered).
- `o_fetch_valid`  out  1  : `o_pointer` is a valid fetch request.
- `o_waiting`  out  1  : high in the WAIT state.
- `o_stopped`  out  1  : high in the STOP state.

## Operation
- States: RST, RUN, WAIT, STOP.
- Async reset sets: state RST, `o_pointer`=`RESET_ADDR`, target=0, counter=0.
- Outputs at reset: `o_fetch_valid`=0, `o_waiting`=0, `o_stopped`=0.
- Mode 2'b01 in any state forces the next state to RST. Pointer is reloaded with `RESET_ADDR`; target and counter are cleared. This has priority over everything below.
- RST: `o_fetch_valid`=0. Mode 2'b10 moves to RUN.
- RUN with mode not 2'b10: freeze. `o_fetch_valid`=0, no updates, commands ignored.
- RUN with mode 2'b10: `o_fetch_valid`=1.
  - With no command: pointer increments by 1 on a fetch handshake (`o_fetch_valid`&`i_fetch_ready`). It wraps modulo 2^DATA_WIDTH (max to 0).
  - Commands are accepted regardless of `i_fetch_ready`:
    - 5: target<=`i_data`; the pointer behaves as with no command.
    - 4: pointer<=target (always taken).
    - 0/1/2/3: taken when a>b / a<b / a==b / a!=b. Taken means pointer<=target, overriding the increment; not taken means the pointer behaves as with no command.
    - 6: `i_data`==0 behaves as no command. Otherwise counter<=`i_data`, state<=WAIT, pointer holds (increment suppressed).
    - 7: state<=STOP, pointer holds.
- WAIT: `o_fetch_valid`=0, `o_waiting`=1, commands ignored. The counter decrements each cycle; when the counter is 1 the state goes to RUN (counter becomes 0).
- STOP: `o_fetch_valid`=0, `o_stopped`=1, pointer holds. Exited only by reset or mode 2'b01.
- `o_fetch_valid`, `o_waiting` and `o_stopped` are decoded combinationally from state and mode. `o_pointer` is a register.

## Timing
- Reset release plus mode 2'b10 at edge E: RUN from E. First fetch of `RESET_ADDR` valid in the cycle after E.
- Jump taken at edge N: `o_pointer`=target in cycle N+1. The request at N is discarded even if the handshake completed.
- Cmd 5 at edge N and a jump at edge N+1 uses the new target. A jump in the same cycle as cmd 5 is impossible (single command).
- Wait of N cycles: `o_fetch_valid` low for exactly N cycles, then fetch resumes at the unchanged pointer.
- Stalled fetch (ready low) holds `o_pointer` stable and valid high.
- Mode 2'b01 mid-WAIT: RST on the next edge, counter cleared.

## Test plan
- Reset then mode 2'b10, ready held high: pointer 0,1,2,3; with W=8, from 0xFF wraps to 0x00.
- ready low for 3 cycles at pointer 5: pointer stays 5 with valid=1; increments to 6 after ready rises.
- Cmd 5 with data 0x40, then cmd 0 with a=3,b=7: not taken, pointer increments. Cmd 0 with a=7,b=3: pointer 0x40 next cycle.
- Cmd 2 and cmd 3 with a=b=9: equal jumps to target, unequal increments. Cmd 4 jumps unconditionally.
- Cmd 6 with data 4 at pointer 10: valid low and waiting high for 4 cycles, then fetch at 10. Cmd 6 with data 0: no wait.
- Cmd 7: stopped=1, pointer frozen, commands ignored. Mode 2'b01 gives pointer `RESET_ADDR`, state RST; async `rst_n` low mid-WAIT clears all immediately.
